// File: rtl/microcode_dispatch.sv
// microcode_dispatch
//   Front-end stage for the microcode sequencer. Incoming instruction words
//   are queued in a small FIFO. The head opcode is presented on `opcode`, and
//   `sos` pulses to start its microcode segment. The stage then waits for `eos`
//   before it retires the word and issues the next one. The halt opcode (6'h3F)
//   parks the sequencer until reset.
//
//   Optional build macro: DISPATCH_WATCHDOG_EN
//     Adds a RUN-cycle watchdog. When it expires, the stuck word is dropped and
//     the sticky `wdog_err` is set. Without the macro, `wdog_err` is tied 0.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   instr, instr_valid   upstream instruction word (opcode = instr[31:26])
//   instr_ready          word accepted this cycle when valid is also high
//   opcode, sos          opcode and start-of-segment pulse to the sequencer
//   eos                  end-of-segment from the sequencer
//   busy                 segment in flight (ISSUE, SETTLE or RUN)
//   halted               halt opcode reached
//   retired              count of completed segments (wraps)
//   wdog_err             watchdog expired (sticky)
module microcode_dispatch #(
    parameter int DEPTH       = 4,
    parameter int RETIRE_W    = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [5:0]          opcode,
    output logic                sos,
    input  logic                eos,
    output logic                busy,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired,
    output logic                wdog_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [5:0]  HALT_OP  = 6'h3F;

    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, RUN, HALT} state_t;
    state_t state;

    // Only the opcode field matters to this stage, so the FIFO stores just that.
    logic unused_payload;
    assign unused_payload = ^instr[25:0];

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [AW:0]   count;
    logic          full, empty, push, pop, wdog_fire;
    logic [5:0]    head_op, next_op;
    logic          next_vld;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign instr_ready = !full && !halted;
    assign push        = instr_valid && instr_ready;
    assign pop         = (state == RUN) && (eos || wdog_fire);
    assign head_op     = mem[rd_ptr];
    assign rd_next     = rd_ptr + 1'b1;

    // Head of the FIFO as it will look after the pop. A word pushed into a
    // single-entry FIFO in the same cycle becomes the new head immediately,
    // so the next segment can issue without an IDLE bubble.
    always_comb begin
        next_vld = 1'b0;
        next_op  = 6'h00;
        if (count > ONE_CNT) begin
            next_vld = 1'b1;
            next_op  = mem[rd_next];
        end else if (push) begin
            next_vld = 1'b1;
            next_op  = instr[31:26];
        end
    end

    // Storage array: no reset. The pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= instr[31:26];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DISPATCH_WATCHDOG_EN
    localparam int          WW        = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0] wdog_cnt;

    // The watchdog fires on the WDOG_CYCLES-th RUN cycle that has eos low.
    assign wdog_fire = (state == RUN) && !eos && (wdog_cnt == WDOG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state == SETTLE)
                wdog_cnt <= '0;
            else if (state == RUN && !eos && !wdog_fire)
                wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_fire) wdog_err <= 1'b1;
        end
    end
`else
    logic [31:0] unused_wdog;
    assign unused_wdog = WDOG_CYCLES;
    assign wdog_fire   = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            opcode  <= 6'h00;
            sos     <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            retired <= '0;
        end else begin
            sos <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_op == HALT_OP) begin
                            state  <= HALT;
                            opcode <= HALT_OP;
                            halted <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                            opcode <= head_op;
                            sos    <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                end
                ISSUE:  state <= SETTLE;
                SETTLE: state <= RUN;
                RUN: begin
                    // eos is only sampled here. A level left over from the
                    // previous segment cannot retire a segment that is still
                    // in ISSUE or SETTLE.
                    if (pop) begin
                        if (eos) retired <= retired + 1'b1;
                        if (!next_vld) begin
                            state  <= IDLE;
                            opcode <= 6'h00;
                            busy   <= 1'b0;
                        end else if (next_op == HALT_OP) begin
                            state  <= HALT;
                            opcode <= HALT_OP;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                            opcode <= next_op;
                            sos    <= 1'b1;
                        end
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
